vga_capture: RTL and testbench

Parametrised pixel-capture front end for the scan converter. It samples a BPP-bit video stream on every clock and packs pixels into WORD_W-bit words. Pixels are framed per line by hsync, with a programmable leading-pixel skip and a fixed number of words per line. Each completed word is offered to the frame-buffer writer through a save/saved handshake with overflow detection. It sits between the input pads and the line/frame buffer controller.

---
 rtl/vga_capture.sv | 134 +++++++++++++
 tb/tb_vga_capture.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// Purpose : packs hsync-framed BPP-bit pixels into WORD_W-bit words for the frame-buffer writer.
// Latency : vd/save valid the cycle after the edge sampling a word's last pixel.
// Backpres: one-word hold register; a completion while the hold is still unaccepted is dropped and sets ovf.
//
// Ports:
//   clk, rst_n          pixel clock, synchronous active-low reset
//   video, hsync, vsync pixel stream and active-high syncs, sampled every edge
//   vd, eol, save       held word, last-word-of-line qualifier, word-available flag
//   saved               one-cycle accept pulse from the consumer
//   ovf                 sticky overflow, cleared on reset or vsync rising edge
module vga_capture #(
    parameter int BPP    = 1,
    parameter int WORD_W = 8,
    parameter int HSKIP  = 0,
    parameter int HWORDS = 80
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BPP-1:0]    video,
    input  logic              hsync,
    input  logic              vsync,
    output logic [WORD_W-1:0] vd,
    output logic              save,
    input  logic              saved,
    output logic              eol,
    output logic              ovf
);

    localparam int PPW   = WORD_W / BPP;
    localparam int PIX_W = $clog2(PPW);

    typedef enum logic [1:0] {IDLE, SKIP, ACTIVE, DONE} state_t;

    state_t            state;
    logic [WORD_W-1:0] shift;
    logic [PIX_W-1:0]  pix_cnt;
    logic [9:0]        skip_cnt;
    logic [9:0]        word_cnt;
    logic              vsync_q;

    logic              sync;
    logic              capture;
    logic              word_done;
    logic              last_word;
    logic [WORD_W-1:0] shift_nxt;

    always_comb begin
        sync      = hsync | vsync;
        // With no skip, the pixel sampled on the IDLE exit edge is already
        // the first captured pixel, so IDLE captures too in that case.
        capture   = !sync && ((state == ACTIVE) || ((state == IDLE) && (HSKIP == 0)));
        word_done = capture && (pix_cnt == PIX_W'(PPW - 1));
        last_word = (word_cnt == 10'(HWORDS - 1));
        shift_nxt = {shift[WORD_W-BPP-1:0], video};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            pix_cnt  <= '0;
            skip_cnt <= '0;
            word_cnt <= '0;
            vsync_q  <= 1'b0;
            vd       <= '0;
            save     <= 1'b0;
            eol      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            vsync_q <= vsync;

            // Line framing: any sync forces IDLE and drops a partial word.
            if (sync) begin
                state    <= IDLE;
                shift    <= '0;
                pix_cnt  <= '0;
                skip_cnt <= '0;
                word_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        // The exit-edge pixel is the first skipped one, so a
                        // skip of one pixel is already complete here.
                        if (HSKIP <= 1) begin
                            state <= ACTIVE;
                        end else begin
                            state    <= SKIP;
                            skip_cnt <= 10'd1;
                        end
                    end
                    SKIP: begin
                        skip_cnt <= skip_cnt + 10'd1;
                        if (skip_cnt + 10'd1 == 10'(HSKIP))
                            state <= ACTIVE;
                    end
                    ACTIVE: begin
                        if (word_done && last_word)
                            state <= DONE;
                    end
                    default: ;  // DONE: hold until a sync
                endcase

                if (capture) begin
                    shift <= shift_nxt;
                    if (word_done) begin
                        pix_cnt  <= '0;
                        word_cnt <= word_cnt + 10'd1;
                    end else begin
                        pix_cnt <= pix_cnt + PIX_W'(1);
                    end
                end
            end

            // Hold register / handshake. A completion coinciding with saved
            // replaces the accepted word without counting as an overflow.
            if (word_done) begin
                if (!save || saved) begin
                    vd   <= shift_nxt;
                    eol  <= last_word;
                    save <= 1'b1;
                end
            end else if (saved) begin
                save <= 1'b0;
            end

            // Set has priority over the vsync-edge clear.
            if (word_done && save && !saved)
                ovf <= 1'b1;
            else if (vsync && !vsync_q)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
module tb_vga_capture;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // a: BPP=1, WORD_W=8, HSKIP=0, HWORDS=2
    logic       a_video, a_hsync, a_vsync, a_saved, a_save, a_eol, a_ovf;
    logic [7:0] a_vd;
    // b: BPP=1, WORD_W=8, HSKIP=3, HWORDS=2
    logic       b_video, b_hsync, b_vsync, b_saved, b_save, b_eol, b_ovf;
    logic [7:0] b_vd;
    // c: BPP=4, WORD_W=16, HSKIP=0, HWORDS=80
    logic [3:0]  c_video;
    logic        c_hsync, c_vsync, c_saved, c_save, c_eol, c_ovf;
    logic [15:0] c_vd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_capture #(.BPP(1), .WORD_W(8), .HSKIP(0), .HWORDS(2)) u_a (
        .clk(clk), .rst_n(rst_n), .video(a_video), .hsync(a_hsync), .vsync(a_vsync),
        .vd(a_vd), .save(a_save), .saved(a_saved), .eol(a_eol), .ovf(a_ovf));

    vga_capture #(.BPP(1), .WORD_W(8), .HSKIP(3), .HWORDS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .video(b_video), .hsync(b_hsync), .vsync(b_vsync),
        .vd(b_vd), .save(b_save), .saved(b_saved), .eol(b_eol), .ovf(b_ovf));

    vga_capture #(.BPP(4), .WORD_W(16), .HSKIP(0), .HWORDS(80)) u_c (
        .clk(clk), .rst_n(rst_n), .video(c_video), .hsync(c_hsync), .vsync(c_vsync),
        .vd(c_vd), .save(c_save), .saved(c_saved), .eol(c_eol), .ovf(c_ovf));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_a(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            a_video = w[i];
            tick();
        end
    endtask

    task automatic feed_b(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            b_video = w[i];
            tick();
        end
    endtask

    initial begin
        logic [7:0] pat;
        a_video = 0; a_hsync = 1; a_vsync = 0; a_saved = 0;
        b_video = 0; b_hsync = 1; b_vsync = 0; b_saved = 0;
        c_video = 0; c_hsync = 1; c_vsync = 0; c_saved = 0;
        rst_n = 0;
        repeat (3) tick();
        check("rst_vd",   a_vd, 0);
        check("rst_save", a_save, 0);
        check("rst_eol",  a_eol, 0);
        check("rst_ovf",  a_ovf, 0);
        check("rst_c_vd", c_vd, 0);
        rst_n = 1;
        tick();

        // Basic two-word line
        a_hsync = 0;
        feed_a(8'hB1);
        check("w1_save", a_save, 1);
        check("w1_vd",   a_vd, 8'hB1);
        check("w1_eol",  a_eol, 0);
        a_saved = 1; a_video = 1;
        tick();
        a_saved = 0;
        check("w1_ack", a_save, 0);
        repeat (7) begin a_video = 1; tick(); end
        check("w2_save", a_save, 1);
        check("w2_vd",   a_vd, 8'hFF);
        check("w2_eol",  a_eol, 1);
        a_saved = 1;
        tick();
        a_saved = 0;
        check("w2_ack", a_save, 0);
        repeat (10) begin a_video = 1; tick(); end
        check("done_nosave", a_save, 0);

        // Overflow when saved withheld; vsync rising clears ovf only
        a_hsync = 1; tick(); a_hsync = 0;
        feed_a(8'hB1);
        check("ov_save1", a_save, 1);
        feed_a(8'h00);
        check("ov_ovf",  a_ovf, 1);
        check("ov_vd",   a_vd, 8'hB1);
        check("ov_save", a_save, 1);
        a_vsync = 1;
        tick();
        check("ov_clear",    a_ovf, 0);
        check("ov_pending",  a_save, 1);
        a_vsync = 0; a_saved = 1;
        tick();
        a_saved = 0;
        check("ov_ack", a_save, 0);

        // saved coincident with the next completion
        a_hsync = 1; tick(); a_hsync = 0;
        feed_a(8'hB1);
        check("sim_save1", a_save, 1);
        pat = 8'h5A;
        for (int i = 7; i >= 1; i--) begin a_video = pat[i]; tick(); end
        a_video = pat[0]; a_saved = 1;
        tick();
        a_saved = 0;
        check("sim_save", a_save, 1);
        check("sim_vd",   a_vd, 8'h5A);
        check("sim_eol",  a_eol, 1);
        check("sim_ovf",  a_ovf, 0);
        a_saved = 1; tick(); a_saved = 0;
        check("sim_ack", a_save, 0);

        // hsync interrupting a partial word
        a_hsync = 1; tick(); a_hsync = 0;
        repeat (5) begin a_video = 1; tick(); end
        a_hsync = 1; tick(); a_hsync = 0;
        check("int_nosave", a_save, 0);
        pat = 8'hB1;
        for (int i = 7; i >= 1; i--) begin a_video = pat[i]; tick(); end
        check("int_fresh7", a_save, 0);
        a_video = pat[0];
        tick();
        check("int_save", a_save, 1);
        check("int_vd",   a_vd, 8'hB1);
        a_saved = 1; tick(); a_saved = 0;

        // Leading skip of 3 junk pixels
        b_hsync = 0;
        b_video = 0; tick();
        b_video = 1; tick();
        b_video = 0; tick();
        feed_b(8'hB1);
        check("sk_save", b_save, 1);
        check("sk_vd",   b_vd, 8'hB1);
        check("sk_eol",  b_eol, 0);
        b_saved = 1; b_video = 1; tick(); b_saved = 0;
        repeat (7) begin b_video = 1; tick(); end
        check("sk_vd2",  b_vd, 8'hFF);
        check("sk_eol2", b_eol, 1);

        // 4-bit pixels, then reset mid-word with a pending overflowed word
        c_hsync = 0;
        for (int i = 1; i <= 4; i++) begin c_video = 4'(i); tick(); end
        check("c_save", c_save, 1);
        check("c_vd",   c_vd, 16'h1234);
        check("c_eol",  c_eol, 0);
        for (int i = 5; i <= 8; i++) begin c_video = 4'(i); tick(); end
        check("c_ovf",  c_ovf, 1);
        check("c_hold", c_vd, 16'h1234);
        c_video = 4'h9; tick();
        c_video = 4'hA; tick();
        rst_n = 0;
        tick();
        check("c_rst_vd",   c_vd, 0);
        check("c_rst_save", c_save, 0);
        check("c_rst_ovf",  c_ovf, 0);
        check("c_rst_eol",  c_eol, 0);
        rst_n = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
